// File: rtl/spi_master_ctrl_if.sv
// Host-side register-access bus of the SPI master sequencer.
// The host drives the request fields; the sequencer returns status and read data.
interface spi_master_ctrl_if;
  logic       req;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (
    output req, rw, addr, wdata,
    input  ready, busy, done, rdata
  );

  modport slave (
    input  req, rw, addr, wdata,
    output ready, busy, done, rdata
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: one 16-bit mode-0 frame {addr, rw, data} per accepted request,
// read data returned with a one-cycle done pulse.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  spi_master_ctrl_if.slave    bus,
  output logic                cs_n_o,
  output logic                sclk_o,
  output logic                mosi_o,
  input  logic                miso_i
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SetupLast = 16'(CS_SETUP - 1);
  localparam logic [15:0] IdleLast  = 16'(CS_IDLE - 1);

  state_e      state_q;
  logic [15:0] div_q;
  logic [3:0]  bit_q;
  logic [14:0] tx_q;   // frame bits still to send after the one on mosi
  logic [7:0]  rx_q;
  logic        rw_q;
  logic        cs_n_q, sclk_q, mosi_q, done_q, busy_q;
  logic [7:0]  rdata_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      div_q  <= div_q + 16'd1;
      unique case (state_q)
        StIdle: begin
          div_q <= '0;
          if (bus.req) begin
            tx_q    <= {bus.addr[5:0], bus.rw, bus.rw ? 8'h00 : bus.wdata};
            mosi_q  <= bus.addr[6];
            rw_q    <= bus.rw;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (div_q == SetupLast) begin
            div_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (div_q == DivLast) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[6:0], miso_i};
            end else begin
              sclk_q <= 1'b0;
              // Last falling edge leaves mosi on bit 0 and closes the frame.
              if (bit_q == 4'd15) begin
                state_q <= StHold;
              end else begin
                bit_q  <= bit_q + 4'd1;
                mosi_q <= tx_q[14];
                tx_q   <= {tx_q[13:0], 1'b0};
              end
            end
          end
        end
        StHold: begin
          if (div_q == DivLast) begin
            div_q   <= '0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StGap;
            if (rw_q) rdata_q <= rx_q;
          end
        end
        StGap: begin
          if (div_q == IdleLast) begin
            div_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign cs_n_o    = cs_n_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: default-parameter and fast-parameter instances, table vectors,
// hand-written corner sequences and random transactions against a frame-level model.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b, sel;
  logic       req_r, rw_r, miso_r;
  logic [6:0] addr_r;
  logic [7:0] wdata_r;
  logic       cs_n_a, sclk_a, mosi_a, cs_n_b, sclk_b, mosi_b;

  spi_master_ctrl_if aif ();
  spi_master_ctrl_if bif ();

  assign aif.req   = req_r & ~sel;
  assign aif.rw    = rw_r;
  assign aif.addr  = addr_r;
  assign aif.wdata = wdata_r;
  assign bif.req   = req_r & sel;
  assign bif.rw    = rw_r;
  assign bif.addr  = addr_r;
  assign bif.wdata = wdata_r;

  spi_master_ctrl u_dut_a (
    .clk_i   (clk),
    .reset_i (reset_a),
    .bus     (aif),
    .cs_n_o  (cs_n_a),
    .sclk_o  (sclk_a),
    .mosi_o  (mosi_a),
    .miso_i  (miso_r)
  );

  spi_master_ctrl #(.CLK_DIV(2), .CS_SETUP(1), .CS_IDLE(1)) u_dut_b (
    .clk_i   (clk),
    .reset_i (reset_b),
    .bus     (bif),
    .cs_n_o  (cs_n_b),
    .sclk_o  (sclk_b),
    .mosi_o  (mosi_b),
    .miso_i  (miso_r)
  );

  logic       s_ready, s_busy, s_done, s_cs_n, s_sclk, s_mosi;
  logic [7:0] s_rdata;
  assign s_ready = sel ? bif.ready : aif.ready;
  assign s_busy  = sel ? bif.busy  : aif.busy;
  assign s_done  = sel ? bif.done  : aif.done;
  assign s_rdata = sel ? bif.rdata : aif.rdata;
  assign s_cs_n  = sel ? cs_n_b : cs_n_a;
  assign s_sclk  = sel ? sclk_b : sclk_a;
  assign s_mosi  = sel ? mosi_b : mosi_a;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_rd [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_frame(input bit rw, input logic [6:0] a,
                                              input logic [7:0] w);
    return {a, rw, rw ? 8'h00 : w};
  endfunction

  // Runs one frame on the selected DUT from the current negedge; cycle n counts from accept.
  task automatic run_xact(input bit rw, input logic [6:0] addr, input logic [7:0] wdata,
                          input logic [7:0] misob, input logic [15:0] exp_frame,
                          input logic [7:0] exp_rdata, input bit keep_req, input bit pulses,
                          output int wait_n, output int ready_n);
    int div, setup, idle, rises, first_rise, done_n, done_cnt, bad;
    logic [15:0] frame;
    logic [7:0]  rd_at_done;
    logic        prev_sclk;
    div   = sel ? 2 : 4;
    setup = sel ? 1 : 2;
    idle  = sel ? 1 : 4;
    rw_r = rw; addr_r = addr; wdata_r = wdata; req_r = 1'b1;
    wait_n = 0;
    ready_n = 0;
    while (!s_ready && wait_n < 500) begin
      @(negedge clk);
      wait_n++;
    end
    if (!s_ready) begin
      check("accept_timeout", 32'(wait_n), 32'd0);
      req_r = 1'b0;
      return;
    end
    rises = 0; first_rise = 0; done_n = 0; done_cnt = 0; bad = 0;
    frame = '0; rd_at_done = '0; prev_sclk = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (!keep_req) req_r = pulses && (n == 10 || n == 100);
      if (n == 1) check("cs_low_after_accept", 32'(s_cs_n), 32'd0);
      if (s_sclk && !prev_sclk) begin
        if (rises == 0) first_rise = n;
        frame = {frame[14:0], s_mosi};
        rises++;
      end
      prev_sclk = s_sclk;
      if (!s_sclk)
        miso_r = (rises >= 8 && rises < 16) ? misob[15-rises] : 1'($urandom_range(0, 1));
      if (s_cs_n && s_mosi) bad++;
      if (!s_ready && !s_busy) bad++;
      if (done_n != 0 && !s_cs_n) bad++;
      if (s_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_n = n;
          rd_at_done = s_rdata;
        end
      end
      if (s_ready) begin
        ready_n = n;
        break;
      end
    end
    check("first_rise_cycle", 32'(first_rise), 32'(1 + setup + div));
    check("sclk_rises", 32'(rises), 32'd16);
    check("mosi_frame", 32'(frame), 32'(exp_frame));
    check("done_cycle", 32'(done_n), 32'(1 + setup + 33 * div));
    check("done_count", 32'(done_cnt), 32'd1);
    check("rdata_at_done", 32'(rd_at_done), 32'(exp_rdata));
    check("ready_cycle", 32'(ready_n), 32'(1 + setup + 33 * div + idle));
    check("pin_rules", 32'(bad), 32'd0);
  endtask

  typedef struct {
    bit          rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  misob;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rdata;
    bit          keep_req;
  } vec_t;

  initial begin
    vec_t        vecs [4];
    int          wn, rn, rises, guard;
    logic        prev_s;
    bit          rw;
    logic [6:0]  a;
    logic [7:0]  w, m, er;

    vecs[0] = '{1'b0, 7'h2A, 8'h55, 8'hFF, 16'h5455, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 7'h13, 8'hEE, 8'hA5, 16'h2700, 8'hA5, 1'b1};
    vecs[2] = '{1'b0, 7'h7F, 8'h0F, 8'h00, 16'hFE0F, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 7'h00, 8'h99, 8'h3C, 16'h0100, 8'h3C, 1'b0};

    sel = 1'b0; req_r = 1'b0; rw_r = 1'b0; addr_r = '0; wdata_r = '0; miso_r = 1'b0;
    reset_a = 1'b1; reset_b = 1'b1;
    model_rd[0] = '0; model_rd[1] = '0;
    repeat (3) @(negedge clk);
    check("reset_cs_n", 32'(cs_n_a), 32'd1);
    check("reset_sclk", 32'(sclk_a), 32'd0);
    check("reset_mosi", 32'(mosi_a), 32'd0);
    check("reset_busy_done", 32'({aif.busy, aif.done}), 32'd0);
    check("reset_rdata", 32'(aif.rdata), 32'd0);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(aif.ready), 32'd1);

    // Table vectors; entry 2 must be accepted in the very cycle ready returns.
    for (int i = 0; i < 4; i++) begin
      run_xact(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].misob, vecs[i].exp_frame,
               vecs[i].exp_rdata, vecs[i].keep_req, 1'b0, wn, rn);
      if (i == 2) check("back_to_back_wait", 32'(wn), 32'd0);
    end
    model_rd[0] = 8'h3C;

    // Request pulses while busy are dropped.
    run_xact(1'b0, 7'h11, 8'h22, 8'h00, model_frame(1'b0, 7'h11, 8'h22), model_rd[0],
             1'b0, 1'b1, wn, rn);
    repeat (6) @(negedge clk);
    check("no_queued_frame", 32'({aif.busy, cs_n_a}), 32'b01);

    // Reset while sclk is high during bit 5.
    rw_r = 1'b1; addr_r = 7'h05; req_r = 1'b1;
    @(negedge clk);
    req_r = 1'b0;
    rises = 0; prev_s = 1'b0; guard = 0;
    while (rises < 6 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (sclk_a && !prev_s) rises++;
      prev_s = sclk_a;
    end
    check("reached_bit5", 32'(rises), 32'd6);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    check("abort_cs_sclk", 32'({cs_n_a, sclk_a}), 32'b10);
    check("abort_busy_ready_done", 32'({aif.busy, aif.ready, aif.done}), 32'b010);
    model_rd[0] = '0;
    run_xact(1'b0, 7'h40, 8'hC3, 8'h00, model_frame(1'b0, 7'h40, 8'hC3), model_rd[0],
             1'b0, 1'b0, wn, rn);

    // Random frames on both parameter sets against the frame-level model.
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        rw = 1'($urandom_range(0, 1));
        a  = 7'($urandom);
        w  = 8'($urandom);
        m  = 8'($urandom);
        er = rw ? m : model_rd[d];
        run_xact(rw, a, w, m, model_frame(rw, a, w), er, 1'($urandom_range(0, 1)), 1'b0,
                 wn, rn);
        model_rd[d] = er;
      end
      req_r = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
